// File: rtl/arith_unit_26_pkg.sv
// Shared opcode encodings and status-bit positions for the arith_unit_26 block.
package arith_unit_26_pkg;

  // Operation select; only the two low opcode bits are decoded.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_ABS = 2'b11
  } op_e;

  // Bit positions inside the 4-bit status word.
  localparam int unsigned ST_Z = 0;
  localparam int unsigned ST_N = 1;
  localparam int unsigned ST_V = 2;
  localparam int unsigned ST_C = 3;

  localparam int unsigned ST_W = 4;

endpackage : arith_unit_26_pkg

// File: rtl/arith_unit_26_alu.sv
// Combinational datapath: add/sub/mul/abs on two's complement operands plus
// Z/N/V/C flag generation. Purely combinational; registered by the top.
module arith_unit_26_alu
  import arith_unit_26_pkg::*;
#(
  parameter int WIDTH_M = 4,
  parameter int WIDTH_N = 2
) (
  input  logic signed [WIDTH_M-1:0] a_i,
  input  logic signed [WIDTH_M-1:0] b_i,
  input  logic        [WIDTH_N-1:0] op_i,
  output logic        [WIDTH_M-1:0] result_o,
  output logic        [ST_W-1:0]    status_o
);

  // One extra bit holds the exact sum/difference/magnitude; the product needs 2*WIDTH_M.
  logic signed [WIDTH_M:0]     a_x, b_x;
  logic signed [WIDTH_M:0]     sum_x, diff_x, abs_x;
  logic        [WIDTH_M:0]     usum;
  logic signed [2*WIDTH_M-1:0] a_w, b_w, prod_w;
  logic        [WIDTH_M:0]     prod_top;
  op_e                         op;

  // Operand extension and the exact-width arithmetic results.
  always_comb begin
    op     = op_e'(op_i[1:0]);
    a_x    = {a_i[WIDTH_M-1], a_i};
    b_x    = {b_i[WIDTH_M-1], b_i};
    sum_x  = a_x + b_x;
    diff_x = a_x - b_x;
    abs_x  = a_x[WIDTH_M] ? -a_x : a_x;
    usum   = {1'b0, a_i} + {1'b0, b_i};
    a_w    = {{WIDTH_M{a_i[WIDTH_M-1]}}, a_i};
    b_w    = {{WIDTH_M{b_i[WIDTH_M-1]}}, b_i};
    prod_w = a_w * b_w;
    // Product fits in WIDTH_M bits only if these upper bits are all sign copies.
    prod_top = prod_w[2*WIDTH_M-1:WIDTH_M-1];
  end

  // Result select and flag generation per opcode.
  always_comb begin
    result_o         = '0;
    status_o         = '0;
    unique case (op)
      OP_ADD: begin
        result_o       = sum_x[WIDTH_M-1:0];
        status_o[ST_V] = sum_x[WIDTH_M] ^ sum_x[WIDTH_M-1];
        status_o[ST_C] = usum[WIDTH_M];
      end
      OP_SUB: begin
        result_o       = diff_x[WIDTH_M-1:0];
        status_o[ST_V] = diff_x[WIDTH_M] ^ diff_x[WIDTH_M-1];
        status_o[ST_C] = ($unsigned(a_i) < $unsigned(b_i));
      end
      OP_MUL: begin
        result_o       = prod_w[WIDTH_M-1:0];
        status_o[ST_V] = ~((&prod_top) | (~|prod_top));
      end
      OP_ABS: begin
        // |most-negative| is representable only in WIDTH_M+1 bits, so it wraps.
        result_o       = abs_x[WIDTH_M-1:0];
        status_o[ST_V] = abs_x[WIDTH_M] ^ abs_x[WIDTH_M-1];
      end
      default: begin
        result_o = '0;
      end
    endcase
    status_o[ST_Z] = ~|result_o;
    status_o[ST_N] = result_o[WIDTH_M-1];
  end

endmodule : arith_unit_26_alu

// File: rtl/arith_unit_26_core.sv
// Top level: one-cycle-latency arithmetic unit. The ALU is combinational;
// this level only registers result and status, with asynchronous clear.
module arith_unit_26_core
  import arith_unit_26_pkg::*;
#(
  parameter int WIDTH_M = 4,
  parameter int WIDTH_N = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [WIDTH_M-1:0] i_arg_A,
  input  logic [WIDTH_M-1:0] i_arg_B,
  input  logic [WIDTH_N-1:0] i_op,
  output logic [WIDTH_M-1:0] o_result,
  output logic [ST_W-1:0]    o_status
);

  logic [WIDTH_M-1:0] result_d, result_q;
  logic [ST_W-1:0]    status_d, status_q;

  arith_unit_26_alu #(
    .WIDTH_M (WIDTH_M),
    .WIDTH_N (WIDTH_N)
  ) u_alu (
    .a_i      (i_arg_A),
    .b_i      (i_arg_B),
    .op_i     (i_op),
    .result_o (result_d),
    .status_o (status_d)
  );

  // Output registers: cleared immediately when reset goes low, else load the ALU outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      result_q <= '0;
      status_q <= '0;
    end else begin
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign o_result = result_q;
  assign o_status = status_q;

endmodule : arith_unit_26_core

// File: tb/tb_arith_unit_26_core.sv
// Bench for arith_unit_26_core (WIDTH_M=4): directed vectors, randomized
// operations against an integer reference model, and reset/hold behaviour.
module tb_arith_unit_26_core;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic [1:0]   op;
  logic [W-1:0] res;
  logic [3:0]   st;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arith_unit_26_core #(
    .WIDTH_M (W),
    .WIDTH_N (2)
  ) dut (
    .i_clk    (clk),
    .i_reset  (rst_n),
    .i_arg_A  (a),
    .i_arg_B  (b),
    .i_op     (op),
    .o_result (res),
    .o_status (st)
  );

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact signed math in plain integers, then truncate and derive flags.
  function automatic void ref_model(input logic [3:0] av, input logic [3:0] bv,
                                    input logic [1:0] ov,
                                    output logic [3:0] r, output logic [3:0] s);
    int sa, sb, ua, ub, ex;
    bit c, v;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    ua = int'(av);
    ub = int'(bv);
    c  = 1'b0;
    case (ov)
      2'd0: begin ex = sa + sb; c = (ua + ub) > 15; end
      2'd1: begin ex = sa - sb; c = ua < ub; end
      2'd2: ex = sa * sb;
      default: ex = (sa < 0) ? -sa : sa;
    endcase
    v = (ex > 7) || (ex < -8);
    r = ex[3:0];
    s = {c, v, r[3], (r == 4'd0)};
  endfunction

  // Drive one operation at the falling edge, check registered outputs after the rising edge.
  task automatic apply(input string tag, input logic [3:0] av, input logic [3:0] bv,
                       input logic [1:0] ov);
    logic [3:0] er, es;
    @(negedge clk);
    a  = av;
    b  = bv;
    op = ov;
    ref_model(av, bv, ov, er, es);
    @(posedge clk);
    #1;
    check_val({tag, "_res"}, {4'h0, res}, {4'h0, er});
    check_val({tag, "_st"},  {4'h0, st},  {4'h0, es});
  endtask

  // Directed vectors with hand-derived expectations: {a, b, op, result, status{C,V,N,Z}}.
  logic [17:0] dir_tab [10] = '{
    {4'b0001, 4'b1000, 2'b00, 4'b1001, 4'b0010},
    {4'b1110, 4'b0010, 2'b00, 4'b0000, 4'b1001},
    {4'b1000, 4'b0010, 2'b01, 4'b0110, 4'b0100},
    {4'b0101, 4'b1111, 2'b01, 4'b0110, 4'b1000},
    {4'b1011, 4'b1011, 2'b10, 4'b1001, 4'b0110},
    {4'b0110, 4'b1111, 2'b10, 4'b1010, 4'b0010},
    {4'b0000, 4'b0101, 2'b11, 4'b0000, 4'b0001},
    {4'b1110, 4'b0011, 2'b11, 4'b0010, 4'b0000},
    {4'b1000, 4'b1111, 2'b11, 4'b1000, 4'b0110},
    {4'b0111, 4'b0111, 2'b00, 4'b1110, 4'b0110}
  };

  initial begin
    logic [17:0] row;
    logic [3:0]  er, es;
    logic [3:0]  held_r, held_s;

    rst_n = 1'b1;
    a     = '0;
    b     = '0;
    op    = '0;

    // Reset: asynchronous clear, held across clock edges.
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_res", {4'h0, res}, 8'h00);
    check_val("rst_st",  {4'h0, st},  8'h00);
    a = 4'h3; b = 4'h4; op = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_hold_res", {4'h0, res}, 8'h00);
    check_val("rst_hold_st",  {4'h0, st},  8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with constant expectations.
    for (int i = 0; i < 10; i++) begin
      row = dir_tab[i];
      @(negedge clk);
      a  = row[17:14];
      b  = row[13:10];
      op = row[9:8];
      @(posedge clk);
      #1;
      check_val($sformatf("dir%0d_res", i), {4'h0, res}, {4'h0, row[7:4]});
      check_val($sformatf("dir%0d_st", i),  {4'h0, st},  {4'h0, row[3:0]});
    end

    // Randomized operations, opcode changing freely every cycle.
    for (int i = 0; i < 300; i++) begin
      apply($sformatf("rnd%0d", i), 4'($urandom), 4'($urandom), 2'($urandom));
    end

    // Inputs changed mid-cycle must not disturb the registered outputs.
    apply("pre_hold", 4'b0011, 4'b0010, 2'b10);
    held_r = res;
    held_s = st;
    @(negedge clk);
    a  = 4'b1000;
    b  = 4'b0001;
    op = 2'b01;
    #2;
    check_val("hold_res", {4'h0, res}, {4'h0, 4'b0110});
    check_val("hold_st",  {4'h0, st},  {4'h0, 4'b0000});
    ref_model(a, b, op, er, es);
    @(posedge clk);
    #1;
    check_val("after_hold_res", {4'h0, res}, {4'h0, er});
    check_val("after_hold_st",  {4'h0, st},  {4'h0, es});
    check_val("hold_changed", {7'h0, (held_r != res)}, 8'h01);

    // Mid-stream reset between edges, then recovery on the first edge after release.
    apply("pre_rst", 4'b0101, 4'b0001, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_res", {4'h0, res}, 8'h00);
    check_val("mid_rst_st",  {4'h0, st},  8'h00);
    a = 4'b0111; b = 4'b0111; op = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    check_val("mid_rst_hold_res", {4'h0, res}, 8'h00);
    check_val("mid_rst_hold_st",  {4'h0, st},  8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    a = 4'b1001; b = 4'b0011; op = 2'b01;
    ref_model(a, b, op, er, es);
    #1;
    check_val("rel_pre_edge_res", {4'h0, res}, 8'h00);
    @(posedge clk);
    #1;
    check_val("rel_res", {4'h0, res}, {4'h0, er});
    check_val("rel_st",  {4'h0, st},  {4'h0, es});

    for (int i = 0; i < 50; i++) begin
      apply($sformatf("rnd2_%0d", i), 4'($urandom), 4'($urandom), 2'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_arith_unit_26_core

// File: doc/arith_unit_26_core.md
ARITH_UNIT_26_CORE -- requirements
Module: arith_unit_26_core

Interface
REQ-001 Parameter WIDTH_M, default 4, operand/result width in bits (two's complement).
REQ-002 Parameter WIDTH_N, default 2, opcode width; only i_op[1:0] is decoded, higher bits ignored.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_reset  input  1  reset, asynchronous, active-low.
REQ-005 i_arg_A  input  WIDTH_M  operand A, signed.
REQ-006 i_arg_B  input  WIDTH_M  operand B, signed; ignored for op 11.
REQ-007 i_op  input  WIDTH_N  operation select.
REQ-008 o_result  output  WIDTH_M  registered result.
REQ-009 o_status  output  4  registered flags: [0] Z zero, [1] N negative, [2] V signed overflow, [3] C carry/borrow.

Function
REQ-010 Op 00 SHALL compute A+B; o_result = low WIDTH_M bits of the sum.
REQ-011 Op 01 SHALL compute A-B; o_result = low WIDTH_M bits of the difference.
REQ-012 Op 10 SHALL compute signed A*B (full 2*WIDTH_M product internally); o_result = low WIDTH_M bits.
REQ-013 Op 11 SHALL compute |A| (signed); o_result = low WIDTH_M bits (|most-negative| wraps to itself).
REQ-014 Z SHALL be 1 iff o_result is all zeros.
REQ-015 N SHALL equal o_result MSB.
REQ-016 V SHALL be 1 iff the exact signed mathematical result is outside [-2^(WIDTH_M-1), 2^(WIDTH_M-1)-1].
REQ-017 C SHALL be unsigned carry-out for op 00, unsigned borrow (A<B unsigned) for op 01, and 0 for ops 10/11.
REQ-018 Inputs SHALL be sampled on each rising i_clk edge while i_reset is high; o_result/o_status update on that edge (latency 1 cycle, no handshake, new operation every cycle).
REQ-019 Outputs SHALL hold their value between clock edges regardless of input changes.
REQ-020 Opcode change between cycles SHALL take effect on the next edge with no pipeline bubble.

Reset
REQ-021 i_reset low SHALL immediately (asynchronously) force o_result=0 and o_status=4'b0000.
REQ-022 While i_reset is low, outputs SHALL stay 0 irrespective of clock and inputs.
REQ-023 After i_reset rises, the first rising edge SHALL register a normal result; reset asserted mid-stream discards any in-flight result.

Structure
REQ-024 Opcode encodings (ADD=00, SUB=01, MUL=10, ABS=11) and status bit indices SHALL be constants/enum in a shared package arith_unit_26_pkg.
REQ-025 Combinational datapath SHALL be one sub-module arith_unit_26_alu (ops + flag generation); top holds only the output registers.
REQ-026 Design SHALL be fully synthesizable, no latches, single always_ff for the registers.

Verification (WIDTH_M=4, status shown as {C,V,N,Z})
REQ-027 Add A=0001,B=1000 -> result 1001, status 0010; add A=1110,B=0010 -> result 0000, status 1001.
REQ-028 Sub A=1000,B=0010 -> result 0110, status 0100; sub A=0101,B=1111 -> result 0110, status 1000.
REQ-029 Mul A=1011,B=1011 -> result 1001, status 0110; mul A=0110,B=1111 -> result 1010, status 0010.
REQ-030 Abs A=0000 -> 0000/0001; A=1110 -> 0010/0000; A=1000 -> 1000/0110.
REQ-031 Drive i_reset low between clock edges after a nonzero result -> outputs 0/0000 immediately, held until i_reset high and next rising edge.
REQ-032 Change inputs mid-cycle (clock low) -> outputs unchanged until next rising edge.
